alu_md: RTL and testbench



---
 rtl/alu_md_if.sv | 16 +
 rtl/alu_md.sv | 147 ++++++++++++++
 tb/tb_alu_md.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_if.sv
// Execute-unit bus: ALU operands/result, mul/div handshake and HI/LO access.
// The master drives operands and control, and the slave (alu_md) returns results.
interface alu_md_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A, B, C;
  logic [3:0]       ALUOp;
  logic             Zero;
  logic             md_start, md_busy, md_done;
  logic [1:0]       md_op;
  logic             hilo_we, hilo_sel;
  logic [WIDTH-1:0] hilo_wdata, hi, lo;

  modport master (output A, B, ALUOp, md_start, md_op, hilo_we, hilo_sel, hilo_wdata,
                  input  C, Zero, md_busy, md_done, hi, lo);
  modport slave  (input  A, B, ALUOp, md_start, md_op, hilo_we, hilo_sel, hilo_wdata,
                  output C, Zero, md_busy, md_done, hi, lo);
endinterface

// File: rtl/alu_md.sv
// Execute unit: combinational integer ALU plus a 1-bit-per-cycle
// multiply/divide engine that writes the HI/LO register pair.
module alu_md #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rstn,
  alu_md_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  // ---------------- ALU ----------------
  logic [WIDTH-1:0] c;
  logic [SHW-1:0]   sh;
  assign sh = bus.A[SHW-1:0];

  always_comb begin
    c = bus.A;
    case (bus.ALUOp)
      4'd1:    c = bus.A + bus.B;
      4'd2:    c = bus.A - bus.B;
      4'd3:    c = bus.A & bus.B;
      4'd4:    c = bus.A | bus.B;
      4'd5:    c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'd6:    c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'd7:    c = bus.B << sh;
      4'd8:    c = ~(bus.A | bus.B);
      4'd9:    c = bus.B >> sh;
      4'd10:   c = bus.B;
      4'd11:   c = $unsigned($signed(bus.B) >>> sh);
      4'd12:   c = bus.A ^ bus.B;
      4'd13:   c = bus.B << (WIDTH/2);
      default: c = bus.A;
    endcase
  end

  assign bus.C    = c;
  assign bus.Zero = (c == {WIDTH{1'b0}});

  // ---------------- mul/div engine ----------------
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, nstate;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   bop;   // multiplicand or divisor magnitude
  logic               is_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy, done;

  logic             sgn_op, sa, sb;
  logic [WIDTH-1:0] amag, bmag;
  assign sgn_op = ~bus.md_op[0];
  assign sa     = sgn_op & bus.A[WIDTH-1];
  assign sb     = sgn_op & bus.B[WIDTH-1];
  assign amag   = sa ? -bus.A : bus.A;
  assign bmag   = sb ? -bus.B : bus.B;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign mul_add  = acc[0] ? bop : {WIDTH{1'b0}};
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  // Extra top bit of the difference is the borrow of the trial subtraction.
  assign div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, bop};
  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE:    if (bus.md_start) nstate = bus.md_op[1] ? DIV : MUL;
      MUL,
      DIV:     begin busy = 1'b1; if (cnt == CW'(1)) nstate = FIX; end
      FIX:     begin busy = 1'b1; nstate = DONE; end
      DONE:    begin done = 1'b1; nstate = IDLE; end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      acc    <= '0;
      bop    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.md_start) begin
            acc    <= {{WIDTH{1'b0}}, bus.md_op[1] ? amag : bmag};
            bop    <= bus.md_op[1] ? bmag : amag;
            cnt    <= CW'(WIDTH);
            is_div <= bus.md_op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= (bus.B == {WIDTH{1'b0}});
          end else if (bus.hilo_we) begin
            if (bus.hilo_sel) hi_q <= bus.hilo_wdata;
            else              lo_q <= bus.hilo_wdata;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - CW'(1);
        end
        DIV: begin
          acc <= div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          // With a zero divisor the remainder path already yields the original dividend.
          if (is_div) begin
            hi_q <= r_fix;
            lo_q <= dz ? {WIDTH{1'b1}} : q_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.md_busy = busy;
  assign bus.md_done = done;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed and random ALU vectors and
// mul/div operations checked against an arithmetic reference model.
module tb_alu_md;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rstn;
  int   ntests = 0;
  int   nfail  = 0;

  alu_md_if #(.WIDTH(W)) bus();
  alu_md #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    longint      sbv;
    logic [63:0] t;
    sh  = a[4:0];
    sbv = longint'(int'(b));
    case (op)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd7:  begin t = 64'(b) * (64'd1 << sh); return t[31:0]; end
      4'd8:  return ~(a | b);
      4'd9:  return b / (32'd1 << sh);
      4'd10: return b;
      4'd11: begin t = 64'(sbv >>> sh); return t[31:0]; end
      4'd12: return a ^ b;
      4'd13: return b * 32'h0001_0000;
      default: return a;
    endcase
  endfunction

  task automatic md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0]        p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    hi = '0; lo = '0;
    case (op)
      2'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd2: if (b == 0) begin hi = a; lo = '1; end
            else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      default: if (b == 0) begin hi = a; lo = '1; end
               else begin lo = a / b; hi = a % b; end
    endcase
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] e;
    bus.ALUOp = op; bus.A = a; bus.B = b;
    #1;
    e = alu_ref(op, a, b);
    chk({tag, "_C"}, 64'(bus.C), 64'(e));
    chk({tag, "_Z"}, 64'(bus.Zero), 64'(e == 0));
  endtask

  task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    logic [31:0] eh, el, ph, pl;
    int k;
    md_ref(op, a, b, eh, el);
    ph = bus.hi; pl = bus.lo;
    bus.md_op = op; bus.A = a; bus.B = b; bus.md_start = 1'b1;
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'($urandom); bus.hilo_wdata = $urandom;
    tick();
    bus.md_start = 1'b0; bus.hilo_we = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.md_op = 2'($urandom);
    chk({tag, "_startwins_hi"}, 64'(bus.hi), 64'(ph));
    chk({tag, "_startwins_lo"}, 64'(bus.lo), 64'(pl));
    k = 1;
    while (bus.md_busy === 1'b1 && k < 100) begin
      if (disturb && k >= 10 && k <= 12) begin
        bus.md_start = 1'b1; bus.hilo_we = 1'b1;
        bus.hilo_sel = k[0]; bus.hilo_wdata = $urandom;
      end else begin
        bus.md_start = 1'b0; bus.hilo_we = 1'b0;
      end
      tick();
      k++;
    end
    bus.md_start = 1'b0; bus.hilo_we = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(k - 1), 64'(W + 1));
    chk({tag, "_done"}, 64'(bus.md_done), 64'd1);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    if (disturb) begin
      bus.md_start = 1'b1; bus.hilo_we = 1'b1; bus.hilo_wdata = $urandom;
    end
    tick();
    bus.md_start = 1'b0; bus.hilo_we = 1'b0;
    chk({tag, "_done_clear"}, 64'(bus.md_done), 64'd0);
    chk({tag, "_idle"}, 64'(bus.md_busy), 64'd0);
    if (disturb) begin
      chk({tag, "_keep_hi"}, 64'(bus.hi), 64'(eh));
      chk({tag, "_keep_lo"}, 64'(bus.lo), 64'(el));
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    rstn = 1'b0;
    bus.A = '0; bus.B = '0; bus.ALUOp = '0; bus.md_start = 1'b0; bus.md_op = '0;
    bus.hilo_we = 1'b0; bus.hilo_sel = 1'b0; bus.hilo_wdata = '0;
    #12;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.md_busy), 64'd0);
    chk("rst_done", 64'(bus.md_done), 64'd0);
    @(negedge clk) rstn = 1'b1;
    tick();

    // ALU directed points
    alu_chk("add", 4'd1, 32'd5, -32'sd3);
    chk("add_val", 64'(bus.C), 64'd2);
    alu_chk("sub", 4'd2, 32'd5, -32'sd3);
    chk("sub_val", 64'(bus.C), 64'd8);
    alu_chk("slt", 4'd5, 32'd5, -32'sd3);
    chk("slt_val", 64'(bus.C), 64'd0);
    alu_chk("sltu", 4'd6, 32'd5, -32'sd3);
    chk("sltu_val", 64'(bus.C), 64'd1);
    alu_chk("sra", 4'd11, 32'd4, 32'h8000_0000);
    chk("sra_val", 64'(bus.C), 64'hF800_0000);
    alu_chk("lui", 4'd13, 32'd0, 32'h0000_1234);
    chk("lui_val", 64'(bus.C), 64'h1234_0000);
    alu_chk("sub_eq", 4'd2, 32'd7, 32'd7);
    chk("sub_eq_zero", 64'(bus.Zero), 64'd1);
    for (int i = 0; i < 48; i++)
      alu_chk("alu_rand", 4'(i % 16), $urandom, $urandom);

    // Directed mul/div
    run_md("mult", 2'd0, -32'sd3, 32'd7, 1'b0);
    chk("mult_hi_c", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_lo_c", 64'(bus.lo), 64'hFFFF_FFEB);
    run_md("multu", 2'd1, -32'sd3, 32'd7, 1'b0);
    chk("multu_hi_c", 64'(bus.hi), 64'h0000_0006);
    run_md("div", 2'd2, -32'sd7, 32'd2, 1'b0);
    chk("div_lo_c", 64'(bus.lo), 64'hFFFF_FFFD);
    run_md("divu", 2'd3, 32'd7, 32'd2, 1'b0);
    chk("divu_lo_c", 64'(bus.lo), 64'd3);
    run_md("div0", 2'd2, 32'd9, 32'd0, 1'b0);
    chk("div0_hi_c", 64'(bus.hi), 64'd9);
    run_md("div0n", 2'd2, -32'sd9, 32'd0, 1'b0);
    run_md("divu0", 2'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_md("divovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_lo_c", 64'(bus.lo), 64'h8000_0000);
    run_md("disturb", 2'd0, 32'd12345, -32'sd678, 1'b1);

    // Direct HI/LO writes in IDLE
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'hABCD;
    ra = bus.lo;
    tick();
    bus.hilo_we = 1'b0;
    chk("mthi_hi", 64'(bus.hi), 64'hABCD);
    chk("mthi_lo_keep", 64'(bus.lo), 64'(ra));
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'h1357_2468;
    tick();
    bus.hilo_we = 1'b0;
    chk("mtlo_lo", 64'(bus.lo), 64'h1357_2468);
    chk("mtlo_hi_keep", 64'(bus.hi), 64'hABCD);

    // Random mul/div
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_md("md_rand", rop, ra, rb, 1'($urandom_range(0, 3) == 0));
    end

    // Reset mid-operation
    bus.md_op = 2'd0; bus.A = 32'h7654_3210; bus.B = 32'h0000_0F0F; bus.md_start = 1'b1;
    tick();
    bus.md_start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("pre_rst_busy", 64'(bus.md_busy), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.md_busy), 64'd0);
    chk("mid_rst_hi", 64'(bus.hi), 64'd0);
    chk("mid_rst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk) rstn = 1'b1;
    tick();
    chk("post_rst_idle", 64'(bus.md_busy), 64'd0);
    run_md("post_rst_multu", 2'd1, 32'd2, 32'd3, 1'b0);
    chk("post_rst_lo_c", 64'(bus.lo), 64'd6);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
